mouse_receiver: RTL
===================

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, max CLK cycles between PS/2 falling edges inside a frame (1 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of input synchroniser (legal 2..3).
REQ-003 CLK  in  1  system clock, all logic on rising edge; only clock.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 CLK_MOUSE_IN  in  1  raw PS/2 clock line from device, asynchronous.
REQ-006 DATA_MOUSE_IN  in  1  raw PS/2 data line from device, asynchronous.
REQ-007 READ_ENABLE  in  1  permission from master state machine to accept frames.
REQ-008 BYTE_READ  out  8  last received data byte.
REQ-009 BYTE_ERROR_CODE  out  2  bit0 = parity error, bit1 = stop-bit error, for byte on BYTE_READ.
REQ-010 BYTE_READY  out  1  single-cycle pulse: BYTE_READ/BYTE_ERROR_CODE newly valid.

Function
REQ-011 Both raw inputs pass through SYNC_STAGES-deep synchronisers; all decisions use synchronised values only.
REQ-012 Falling edge = synchronised clock 1 on previous cycle, 0 on current; exactly one edge event per PS/2 falling edge.
REQ-013 States: IDLE, START, DATA, PARITY, STOP, DONE.
REQ-014 IDLE -> DATA on falling edge with sampled data 0 and READ_ENABLE 1; data 1 (bad start) stays in IDLE, no output change.
REQ-015 DATA: each falling edge shifts sampled bit into shift register, LSB first; 3-bit bit counter; after 8th bit -> PARITY.
REQ-016 PARITY: on falling edge capture bit; parity error = XOR of 8 data bits and parity bit equals 0 (odd parity required) -> STOP.
REQ-017 STOP: on falling edge capture bit; stop error = sampled bit 0 -> DONE.
REQ-018 DONE lasts exactly one cycle: BYTE_READ <= shift register, BYTE_ERROR_CODE <= {stop err, parity err}, BYTE_READY = 1; then -> IDLE.
REQ-019 Latency: BYTE_READY high on the CLK cycle after the cycle in which the stop-bit edge event is detected.
REQ-020 Errors never suppress BYTE_READY; byte delivered with error code, master decides.
REQ-021 BYTE_READ and BYTE_ERROR_CODE hold value until next DONE; unchanged by aborted frames.
REQ-022 Timeout counter clears on every edge event and in IDLE; increments otherwise; reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE, shift register and bit counter cleared, no BYTE_READY.
REQ-023 READ_ENABLE deasserted in any state other than IDLE/DONE aborts to IDLE next cycle, no BYTE_READY; in DONE the pulse still completes.
REQ-024 Timeout and READ_ENABLE abort coinciding with an edge event: abort wins, edge ignored.
REQ-025 Timeout counter saturates, never wraps; width = $clog2(TIMEOUT_CYCLES).

Reset
REQ-026 RESET high on rising CLK: state IDLE, BYTE_READ 8'h00, BYTE_ERROR_CODE 2'b00, BYTE_READY 0, counters and shift register 0, synchroniser flops 1 (idle line level).
REQ-027 RESET mid-frame discards partial frame; first edge event after release is treated as possible start bit.

Structure
REQ-028 Shared package mouse_pkg holds state enum, error-code bit positions (ERR_PARITY=0, ERR_STOP=1) and default TIMEOUT_CYCLES.
REQ-029 Sub-module ps2_sync_edge contains synchroniser plus falling-edge detector, instantiated once, for clock and data.
REQ-030 Outputs registered; no combinational path from raw inputs to any output.

Verification
REQ-031 Frame 0xFA, correct parity 1, stop 1, READ_ENABLE 1 -> one BYTE_READY pulse, BYTE_READ 8'hFA, BYTE_ERROR_CODE 2'b00.
REQ-032 Frame 0x08 with parity bit 1 (wrong; odd parity needs 0) -> BYTE_READ 8'h08, BYTE_ERROR_CODE 2'b01; stop bit 0 with correct parity -> 2'b10.
REQ-033 Three back-to-back frames 0x09, 0x05, 0xFE -> exactly three pulses, in order, each 1 cycle wide.
REQ-034 PS/2 clock stops after 4 data bits -> no BYTE_READY, return to IDLE after TIMEOUT_CYCLES-1 cycles; next full frame 0xAA received correctly.
REQ-035 READ_ENABLE dropped after bit 3 -> no pulse, BYTE_READ keeps previous value; READ_ENABLE 0 at start bit -> frame ignored.
REQ-036 RESET asserted mid-frame for 1 cycle -> all outputs at reset values next cycle; following frame 0xF4 delivered with code 2'b00.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse byte receiver.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  localparam int ERR_PARITY             = 0;
  localparam int ERR_STOP               = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  // PS/2 frames use odd parity: the nine bits must contain an odd number of ones.
  function automatic logic parity_error(input logic [7:0] data, input logic parity_bit);
    return ~(^{data, parity_bit});
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines and flags each PS/2 clock falling edge.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic fall_o
);

  logic [STAGES-1:0] clk_sync_q;
  logic [STAGES-1:0] data_sync_q;
  logic              clk_prev_q;

  // Idle PS/2 lines are high, so all stages reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[STAGES-1];
    end
  end

  assign data_o = data_sync_q[STAGES-1];
  assign fall_o = clk_prev_q & ~clk_sync_q[STAGES-1];

endmodule

// File: rtl/mouse_receiver.sv
// Receives 11-bit PS/2 device frames and presents each byte with its parity/stop error code.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    byte_q, byte_d;
  logic [1:0]    err_q, err_d;
  logic          ps2_data;
  logic          ps2_fall;
  logic          abort;

  ps2_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .ps2_clk_i  (CLK_MOUSE_IN),
    .ps2_data_i (DATA_MOUSE_IN),
    .data_o     (ps2_data),
    .fall_o     (ps2_fall)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      par_err_q <= 1'b0;
      timer_q   <= '0;
      byte_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      par_err_q <= par_err_d;
      timer_q   <= timer_d;
      byte_q    <= byte_d;
      err_q     <= err_d;
    end
  end

  // Aborts are evaluated before the edge so a coinciding edge is dropped.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_err_d = par_err_q;
    byte_d    = byte_q;
    err_d     = err_q;
    abort     = (timer_q == TIMER_LAST) || !READ_ENABLE;

    if (state_q == IDLE || ps2_fall) begin
      timer_d = '0;
    end else if (timer_q != {TW{1'b1}}) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      IDLE: begin
        if (ps2_fall && !ps2_data && READ_ENABLE) begin
          state_d = DATA;
        end
      end
      DATA, PARITY, STOP: begin
        if (abort) begin
          state_d   = IDLE;
          shift_d   = '0;
          bitcnt_d  = '0;
          par_err_d = 1'b0;
        end else if (ps2_fall) begin
          if (state_q == DATA) begin
            shift_d  = {ps2_data, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end else if (state_q == PARITY) begin
            par_err_d = parity_error(shift_q, ps2_data);
            state_d   = STOP;
          end else begin
            byte_d            = shift_q;
            err_d[ERR_PARITY] = par_err_q;
            err_d[ERR_STOP]   = ~ps2_data;
            state_d           = DONE;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        shift_d   = '0;
        bitcnt_d  = '0;
        par_err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BYTE_READY      = (state_q == DONE);
    BYTE_READ       = byte_q;
    BYTE_ERROR_CODE = err_q;
  end

endmodule
